// File: rtl/abs_diff_stage_pkg.sv
// -----------------------------------------------------------------------------
// abs_diff_stage_pkg
//   Shared edge-detection defaults: the switch-box/actor port width, the
//   pixel width and line length used by the gradient actors, and the input
//   FIFO depth. Also holds a small width helper for counters.
// -----------------------------------------------------------------------------
package abs_diff_stage_pkg;

    // Port width shared by the switch boxes and the actors
    localparam int unsigned ED_SIZE   = 32;
    // Pixel width taken from the low bits of each port word
    localparam int unsigned ED_PIX_W  = 8;
    // Pixels per image line
    localparam int unsigned ED_LINE_W = 640;
    // Default actor input FIFO depth
    localparam int unsigned ED_DEPTH  = 4;

    // Bits needed to index n positions; never less than one bit
    function automatic int unsigned width_of(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/abs_diff_stage_if.sv
// -----------------------------------------------------------------------------
// abs_diff_stage_if
//   One data/wr/full stream port of the edge-detection datapath.
//   master : drives data and wr, observes full
//   slave  : observes data and wr, drives full
//   Signals:
//     data  SIZE  payload word
//     wr    1     write strobe, one word per high cycle
//     full  1     receiver cannot take a word
// -----------------------------------------------------------------------------
interface abs_diff_stage_if
    import abs_diff_stage_pkg::*;
#(
    parameter int unsigned SIZE = ED_SIZE
);
    logic [SIZE-1:0] data;
    logic            wr;
    logic            full;

    modport master (output data, output wr, input full);
    modport slave  (input data, input wr, output full);
endinterface

// File: rtl/abs_diff_stage_fifo.sv
// -----------------------------------------------------------------------------
// stage_fifo
//   Synchronous FIFO in front of an actor. A push while full and a pop while
//   empty are ignored. Push and pop in the same cycle both take effect.
//   Ports:
//     clock    in   rising-edge clock
//     reset    in   asynchronous active-low reset (empties the FIFO)
//     i_push   in   write request
//     i_din    in   write data, SIZE bits
//     i_pop    in   read request
//     o_dout   out  head-of-queue word (valid while o_empty is low)
//     o_full   out  count == DEPTH
//     o_empty  out  count == 0
//     o_count  out  number of stored words, log2(DEPTH)+1 bits
// -----------------------------------------------------------------------------
module stage_fifo
    import abs_diff_stage_pkg::*;
#(
    parameter int unsigned SIZE  = ED_PIX_W,
    parameter int unsigned DEPTH = ED_DEPTH
)(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [SIZE-1:0]          i_din,
    input  logic                     i_pop,
    output logic [SIZE-1:0]          o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [SIZE-1:0] r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;

    logic            w_push;
    logic            w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd_ptr];

    // Full is judged on the registered count, so a pop in the same cycle
    // does not open a slot for a push until the next cycle.
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop  && !o_empty;

    // Pointers are AW bits wide and DEPTH is a power of two, so they wrap
    // modulo DEPTH naturally.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the empty count keeps stale words unreachable.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

endmodule

// File: rtl/abs_diff_stage.sv
// -----------------------------------------------------------------------------
// abs_diff_stage
//   Horizontal gradient actor: for each pixel of a line it emits the absolute
//   difference to its left neighbour; the first pixel of each line emits 0.
//   Input words are buffered in a small FIFO so upstream writes are absorbed
//   while the downstream port is full.
//   Ports:
//     clock   in      rising-edge clock
//     reset   in      asynchronous active-low reset
//     in1     slave   upstream stream: data (low PIX_W bits used), wr, full
//     out1    master  downstream stream: data (zero-extended result), wr, full
// -----------------------------------------------------------------------------
module abs_diff_stage
    import abs_diff_stage_pkg::*;
#(
    parameter int unsigned SIZE   = ED_SIZE,
    parameter int unsigned PIX_W  = ED_PIX_W,
    parameter int unsigned LINE_W = ED_LINE_W,
    parameter int unsigned DEPTH  = ED_DEPTH
)(
    input  logic              clock,
    input  logic              reset,
    abs_diff_stage_if.slave   in1,
    abs_diff_stage_if.master  out1
);

    localparam int unsigned      COL_W    = width_of(LINE_W);
    localparam int unsigned      CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_W - 1);

    logic [PIX_W-1:0] w_pix;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [CNT_W-1:0] w_fifo_count;
    logic             w_pop;
    logic [PIX_W:0]   w_diff;
    logic [PIX_W:0]   w_diff_neg;
    logic [PIX_W-1:0] w_mag;
    logic [PIX_W-1:0] w_result;

    logic [COL_W-1:0] r_col;
    logic [PIX_W-1:0] r_prev;
    logic [PIX_W-1:0] r_out_pix;
    logic             r_out_wr;

    stage_fifo #(
        .SIZE  (PIX_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (in1.wr),
        .i_din   (in1.data[PIX_W-1:0]),
        .i_pop   (w_pop),
        .o_dout  (w_pix),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // Upper input bits carry no pixel information.
    if (PIX_W < SIZE) begin : g_in_hi
        logic w_unused_hi;
        assign w_unused_hi = ^in1.data[SIZE-1:PIX_W];
    end

    logic w_unused_cnt;
    assign w_unused_cnt = ^w_fifo_count;

    assign in1.full  = w_fifo_full;
    assign out1.wr   = r_out_wr;
    assign out1.data = SIZE'(r_out_pix);

    // out1.full only gates the pop; a word already in r_out_wr still goes out.
    assign w_pop = !w_fifo_empty && !out1.full;

    // Signed difference in PIX_W+1 bits, then magnitude; fits PIX_W bits.
    always_comb begin
        w_diff     = {1'b0, w_pix} - {1'b0, r_prev};
        w_diff_neg = '0 - w_diff;
        w_mag      = w_diff[PIX_W] ? w_diff_neg[PIX_W-1:0] : w_diff[PIX_W-1:0];
        w_result   = (r_col == '0) ? '0 : w_mag;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_col     <= '0;
            r_prev    <= '0;
            r_out_pix <= '0;
            r_out_wr  <= 1'b0;
        end else begin
            r_out_wr <= w_pop;
            if (w_pop) begin
                r_out_pix <= w_result;
                r_prev    <= w_pix;
                r_col     <= (r_col == COL_LAST) ? '0 : r_col + 1'b1;
            end
        end
    end

endmodule
